// File: rtl/led_seq_pkg.sv
// Shared definitions for the aleatory LED sequence checker: the fixed 8-step
// code sequence, its inverse lookup and the checker state encoding.
package led_seq_pkg;

   localparam int CODE_W = 3;

   typedef logic [CODE_W-1:0] code_t;

   typedef enum logic [1:0] {
      SEARCH = 2'd0,
      VERIFY = 2'd1,
      LOCKED = 2'd2
   } state_e;

   localparam code_t SEQ [8] = '{
      3'b000, 3'b101, 3'b010, 3'b111, 3'b001, 3'b110, 3'b011, 3'b100
   };

   function automatic code_t seq_at(code_t pos);
      return SEQ[pos];
   endfunction

   // Every code appears exactly once in SEQ, so the search always hits.
   function automatic code_t seq_inv(code_t code);
      code_t pos;
      pos = '0;
      for (int i = 0; i < 8; i++) begin
         if (SEQ[i] == code) pos = code_t'(i);
      end
      return pos;
   endfunction

endpackage

// File: rtl/led_seq_checker_3x8_if.sv
// Bundle between the LED code source (master) and the sequence checker (slave).
// Handshake: none; led_in is sampled on every rising clk edge, outputs are registered.
interface led_seq_checker_3x8_if
   import led_seq_pkg::*;
#(
   parameter int ERR_W = 8
);
   code_t             led_in;
   code_t             index;
   logic              locked;
   logic              err;
   logic              wrap;
   logic [ERR_W-1:0]  err_count;
   state_e            state;

   modport master (
      output led_in,
      input  index, locked, err, wrap, err_count, state
   );

   modport slave (
      input  led_in,
      output index, locked, err, wrap, err_count, state
   );

endinterface

// File: rtl/led_seq_checker_3x8.sv
// Receives the 3-bit aleatory counter code, decodes its sequence position,
// locks after LOCK_LEN correct successors and counts out-of-sequence codes.
module led_seq_checker_3x8
   import led_seq_pkg::*;
#(
   parameter int LOCK_LEN = 4,
   parameter int ERR_W    = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   led_seq_checker_3x8_if.slave  bus
);

   localparam logic [3:0]       LOCK_LEN_C = 4'(LOCK_LEN);
   localparam logic [ERR_W-1:0] ERR_MAX    = {ERR_W{1'b1}};

   state_e           state_q, state_d;
   code_t            pos_q, pos_d;
   logic [3:0]       match_q, match_d;
   logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
   logic             err_q, err_d;
   logic             wrap_q, wrap_d;
   logic             locked_q, locked_d;

   code_t pos_next;
   code_t inv_code;
   logic  hit;

   assign pos_next = pos_q + 3'd1;
   assign inv_code = seq_inv(bus.led_in);
   assign hit      = (bus.led_in == seq_at(pos_next));

   always_comb begin
      state_d   = state_q;
      pos_d     = pos_q;
      match_d   = match_q;
      err_cnt_d = err_cnt_q;
      err_d     = 1'b0;
      wrap_d    = 1'b0;
      unique case (state_q)
         SEARCH: begin
            pos_d   = inv_code;
            match_d = '0;
            state_d = VERIFY;
         end
         VERIFY: begin
            if (hit) begin
               pos_d   = pos_next;
               match_d = match_q + 4'd1;
               if (match_d == LOCK_LEN_C) state_d = LOCKED;
            end else begin
               pos_d   = inv_code;
               match_d = '0;
            end
         end
         LOCKED: begin
            if (hit) begin
               pos_d  = pos_next;
               wrap_d = (pos_q == 3'd7);
            end else begin
               err_d     = 1'b1;
               err_cnt_d = (err_cnt_q == ERR_MAX) ? err_cnt_q : err_cnt_q + 1'b1;
               pos_d     = inv_code;
               match_d   = '0;
               state_d   = VERIFY;
            end
         end
         default: state_d = SEARCH;
      endcase
      // locked follows the state being entered so it drops on the erroring edge.
      locked_d = (state_d == LOCKED);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= SEARCH;
         pos_q     <= '0;
         match_q   <= '0;
         err_cnt_q <= '0;
         err_q     <= 1'b0;
         wrap_q    <= 1'b0;
         locked_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         pos_q     <= pos_d;
         match_q   <= match_d;
         err_cnt_q <= err_cnt_d;
         err_q     <= err_d;
         wrap_q    <= wrap_d;
         locked_q  <= locked_d;
      end
   end

   assign bus.index     = pos_q;
   assign bus.locked    = locked_q;
   assign bus.err       = err_q;
   assign bus.wrap      = wrap_q;
   assign bus.err_count = err_cnt_q;
   assign bus.state     = state_q;

endmodule

// File: doc/led_seq_checker_3x8.md
# led_seq_checker_3x8

Sequence checker and decoder for the 3-bit aleatory counter's LED output. It samples the 3-bit code on every clock, maps each code back to its position (0..7) in the fixed 8-step aleatory sequence, and acquires lock after a run of correct successors. It then flags every out-of-sequence code and counts errors. It sits beside the aleatory counter, on the same clock, as its receiving and monitoring end.

## Interface
Parameters:
- LOCK_LEN, 4: consecutive correct successor codes needed to enter LOCKED; legal range 1..15.
- ERR_W, 8: width of the saturating error counter.

Ports:
- clk  in  1  single system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- led_in  in  3  code from the aleatory counter; sampled every rising edge.
- index  out  3  sequence position of the last sampled code.
- locked  out  1  high while in LOCKED.
- err  out  1  one-cycle pulse on a mismatch while LOCKED.
- err_count  out  ERR_W  number of LOCKED mismatches; saturates at 2^ERR_W-1.
- wrap  out  1  one-cycle pulse when a correct step 7->0 occurs in LOCKED.

## Operation
- Fixed sequence SEQ[0..7] = 000, 101, 010, 111, 001, 110, 011, 100, then back to SEQ[0]. SEQ[0] = 000 is the counter's reset value.
- INV is the inverse of SEQ. Every 3-bit code is valid, so INV is total.
- Expected next code: SEQ[(pos+1) mod 8]. Position arithmetic is 3-bit and wraps naturally.
- FSM states: SEARCH, VERIFY, LOCKED. The reset state is SEARCH.
- SEARCH, on any code: pos <= INV(led_in), match <= 0, go to VERIFY. SEARCH lasts exactly one cycle after reset release.
- VERIFY, led_in == expected: pos++, match++. When match reaches LOCK_LEN, go to LOCKED.
- VERIFY, mismatch: re-acquire with pos <= INV(led_in), match <= 0, stay in VERIFY. No err pulse.
- LOCKED, led_in == expected: pos++. If the step was 7->0, pulse wrap.
- LOCKED, mismatch:
  - pulse err;
  - err_count++ (saturating);
  - pos <= INV(led_in), match <= 0;
  - go to VERIFY; locked drops in the same update.
- index always equals pos.
- err_count clears only on reset.

## Timing
- Reset values: index=0, locked=0, err=0, err_count=0, wrap=0, state=SEARCH, match=0.
- All outputs are registered. A code present on led_in before edge k is reflected on index, locked, err and wrap immediately after edge k. Latency is 1 cycle; there is no combinational path from input to output.
- Lock time after reset release with a clean sequence: 1 SEARCH edge plus LOCK_LEN VERIFY edges. locked rises after edge LOCK_LEN+1.
- err and wrap are never both high. A mismatch on the cycle where a 7->0 step was expected gives err only.
- At saturation, err still pulses and err_count holds at 2^ERR_W-1.
- Reset asserted mid-operation: outputs clear asynchronously. The first edge after release is treated as SEARCH.
- A static led_in (counter stalled) is a mismatch every cycle. While LOCKED, this gives one err pulse, then VERIFY re-acquires each cycle and locked stays 0.

## Structure
- Package led_seq_pkg holds:
  - the SEQ constant array;
  - an INV lookup function;
  - the state enum (SEARCH, VERIFY, LOCKED);
  - the width constant for the 3-bit code.
- There is no sub-module. It is a single module with one FSM, a pos register, a match counter and the saturating err_count. Expected RTL size is roughly 120-180 lines.
- The verification bench instantiates the aleatory counter as the stimulus source and a behavioural code injector for fault cases.

## Test plan
- Clean lock: pulse reset 10 time units, then drive the real counter. Required: locked=1 after edge 5 (LOCK_LEN=4), index tracks 0..7, wrap pulses once per 8 cycles, err_count=0 after 200 cycles.
- Single fault: while LOCKED at index=2 (code 010), inject 110 instead of 111. Required:
  - err=1 for exactly one cycle, err_count=1, locked=0, index=5;
  - locked returns 4 correct steps later.
- Stall: hold led_in=101 for 6 cycles while LOCKED. Required: one err pulse, err_count=1, locked=0 throughout, index=1.
- Saturation: with ERR_W=2, cause 5 LOCKED mismatches, relocking between each. Required: err pulses 5 times, err_count sticks at 3.
- Reset mid-lock: assert reset asynchronously between edges while index=6. Required:
  - all outputs go to 0 before the next edge;
  - after release, locked rises at edge LOCK_LEN+1.
- Wrap/err exclusivity: at index=7, inject 011 instead of 000. Required: err=1, wrap=0, index=6.
